// File: rtl/connect_count_feeder.sv
// connect_count_feeder: producer side of the connected-count core input port.
// Graph jobs from the upstream distributor are buffered in a FIFO. Each core
// request pops one job, or records a bubble when the FIFO is empty. The popped
// job reaches the core DATA_IN_LATENCY cycles later. Its starting connect count
// follows on a separate line that is STARTING_CONNECT_COUNT_LAG cycles longer.
//
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   inValid/inReady                 upstream job handshake
//   inGraph/inStartCount/inExtraData upstream job payload
//   request                         core asks for a graph this cycle
//   start/graphOut/extraDataOut     graph presented to the core (zero on bubbles)
//   startingConnectCountOut_DELAYED starting count, one-cycle pulse after the lag
//   missedSlots                     saturating count of bubble-answered requests
//   occupancy                       current FIFO fill level
module connect_count_feeder #(
    parameter int unsigned EXTRA_DATA_WIDTH           = 10,
    parameter int unsigned DATA_IN_LATENCY            = 4,
    parameter int unsigned STARTING_CONNECT_COUNT_LAG = 3,
    parameter int unsigned FIFO_DEPTH                 = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            inValid,
    output logic                            inReady,
    input  logic [127:0]                    inGraph,
    input  logic [5:0]                      inStartCount,
    input  logic [EXTRA_DATA_WIDTH-1:0]     inExtraData,
    input  logic                            request,
    output logic                            start,
    output logic [127:0]                    graphOut,
    output logic [5:0]                      startingConnectCountOut_DELAYED,
    output logic [EXTRA_DATA_WIDTH-1:0]     extraDataOut,
    output logic [31:0]                     missedSlots,
    output logic [$clog2(FIFO_DEPTH):0]     occupancy
);

    localparam int unsigned GRAPH_W = 128;
    localparam int unsigned COUNT_W = 6;
    localparam int unsigned TAG_W   = EXTRA_DATA_WIDTH;
    localparam int unsigned ENTRY_W = GRAPH_W + TAG_W + COUNT_W;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W   = PTR_W + 1;
    localparam int unsigned MISS_W  = 32;
    localparam int unsigned DL_LEN  = DATA_IN_LATENCY;
    localparam int unsigned CL_LEN  = DATA_IN_LATENCY + STARTING_CONNECT_COUNT_LAG;

    // FIFO storage: entry = {count, tag, graph}
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               ready_q, ready_d;
    logic [MISS_W-1:0]  missed_q, missed_d;

    // Job delay line (valid/graph/tag) and the longer count delay line
    logic               dv_q [DL_LEN];
    logic [GRAPH_W-1:0] dg_q [DL_LEN];
    logic [TAG_W-1:0]   dt_q [DL_LEN];
    logic [COUNT_W-1:0] cl_q [CL_LEN];

    logic               push_c;
    logic               pop_c;
    logic [ENTRY_W-1:0] head_c;
    logic [GRAPH_W-1:0] graph_in_c;
    logic [TAG_W-1:0]   tag_in_c;
    logic [COUNT_W-1:0] cnt_in_c;

    // Ready is registered from the count, so a pop never frees a slot for a
    // same-cycle push; pop looks at pre-push occupancy, so there is no bypass.
    assign push_c = inValid & ready_q;
    assign pop_c  = request & (occ_q != '0);
    assign head_c = mem_q[rd_ptr_q];

    // Bubbles inject zeros so the outputs read zero whenever start is low
    assign graph_in_c = pop_c ? head_c[GRAPH_W-1:0]                 : '0;
    assign tag_in_c   = pop_c ? head_c[GRAPH_W +: TAG_W]            : '0;
    assign cnt_in_c   = pop_c ? head_c[GRAPH_W + TAG_W +: COUNT_W]  : '0;

    // Next-state for pointers, occupancy, ready and the miss counter
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        missed_d = missed_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push_c, pop_c})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        if (request && (occ_q == '0) && (missed_q != '1)) begin
            missed_d = missed_q + MISS_W'(1);
        end

        ready_d = (occ_d < OCC_W'(FIFO_DEPTH));
    end

    // Control state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ready_q  <= 1'b0;
            missed_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ready_q  <= ready_d;
            missed_q <= missed_d;
        end
    end

    // Payload storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= {inStartCount, inExtraData, inGraph};
        end
    end

    // Job delay line: plain shift register, no stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DL_LEN); i++) begin
                dv_q[i] <= 1'b0;
                dg_q[i] <= '0;
                dt_q[i] <= '0;
            end
        end else begin
            dv_q[0] <= pop_c;
            dg_q[0] <= graph_in_c;
            dt_q[0] <= tag_in_c;
            for (int i = 1; i < int'(DL_LEN); i++) begin
                dv_q[i] <= dv_q[i-1];
                dg_q[i] <= dg_q[i-1];
                dt_q[i] <= dt_q[i-1];
            end
        end
    end

    // Count delay line: lag extra stages beyond the job line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(CL_LEN); i++) begin
                cl_q[i] <= '0;
            end
        end else begin
            cl_q[0] <= cnt_in_c;
            for (int i = 1; i < int'(CL_LEN); i++) begin
                cl_q[i] <= cl_q[i-1];
            end
        end
    end

    assign inReady                         = ready_q;
    assign start                           = dv_q[DL_LEN-1];
    assign graphOut                        = dg_q[DL_LEN-1];
    assign extraDataOut                    = dt_q[DL_LEN-1];
    assign startingConnectCountOut_DELAYED = cl_q[CL_LEN-1];
    assign missedSlots                     = missed_q;
    assign occupancy                       = occ_q;

endmodule

// File: doc/connect_count_feeder.md
Name: connect_count_feeder

Overview:
- Producer end of the connected-count core's input interface: answers each core `request` pulse with a graph.
- Buffers graph jobs arriving from the upstream distributor in a FIFO.
- Drives `start`, `graphOut` and `extraDataOut` exactly DATA_IN_LATENCY cycles after the request.
- Drives `startingConnectCountOut_DELAYED` STARTING_CONNECT_COUNT_LAG cycles after `start`.
- Counts request slots that could not be filled.

Parameters:
- EXTRA_DATA_WIDTH, 10, width of the per-job tag carried alongside the graph.
- DATA_IN_LATENCY, 4, cycles from core `request` to `start`; legal range ≥1.
- STARTING_CONNECT_COUNT_LAG, 3, cycles from `start` to the starting connect count; legal range ≥0.
- FIFO_DEPTH, 16, job FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- inValid  in  1  upstream job valid.
- inReady  out  1  FIFO can accept a job.
- inGraph  in  128  upstream graph.
- inStartCount  in  6  upstream starting connect count.
- inExtraData  in  EXTRA_DATA_WIDTH  upstream job tag.
- request  in  1  core asks for a new graph this cycle.
- start  out  1  graph presented to the core this cycle.
- graphOut  out  128  graph to the core; zero when start=0.
- startingConnectCountOut_DELAYED  out  6  starting count, lagging start by STARTING_CONNECT_COUNT_LAG cycles.
- extraDataOut  out  EXTRA_DATA_WIDTH  tag, aligned with start; zero when start=0.
- missedSlots  out  32  saturating count of requests answered with a bubble.
- occupancy  out  log2(FIFO_DEPTH)+1  current FIFO fill level.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied; all delay-line stages cleared.
  - start, graphOut, extraDataOut, startingConnectCountOut_DELAYED, missedSlots and occupancy all 0.
  - inReady=0 while reset is asserted; inReady=1 from the first clock edge after release.
- Reset mid-operation: all in-flight and buffered jobs are discarded; no start is emitted for them.
- FIFO push:
  - Occurs on any edge with inValid & inReady.
  - inReady = (occupancy < FIFO_DEPTH), registered from the count.
  - inReady is not pop-aware: when full, a same-cycle pop does not admit a push.
- FIFO pop:
  - Occurs on any edge with request & (occupancy ≠ 0).
  - Occupancy sampled before this edge's push; a job pushed in cycle t is poppable from t+1 (no bypass).
- Simultaneous push and pop: occupancy unchanged.
- Request with empty FIFO:
  - Bubble: start=0 at t+DATA_IN_LATENCY, graphOut=0.
  - missedSlots increments, saturating at 0xFFFFFFFF.
- Request timing:
  - A request at edge t yields start=1 during cycle t+DATA_IN_LATENCY, carrying the popped graph and tag.
  - Requests on consecutive cycles yield starts on consecutive cycles.
  - Pipeline throughput: 1 job per cycle.
- Starting count:
  - The popped inStartCount travels a separate delay line.
  - It appears on startingConnectCountOut_DELAYED at t+DATA_IN_LATENCY+STARTING_CONNECT_COUNT_LAG.
  - The value holds for exactly one cycle, then returns to 0.
  - With LAG=0 it aligns with start.
- No request: start=0; the FIFO is untouched.
- Storage:
  - FIFO entry width = 128 + 6 + EXTRA_DATA_WIDTH.
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - occupancy is a separate up/down counter that never exceeds FIFO_DEPTH or drops below 0.
- Ordering: strictly FIFO; jobs are never reordered or duplicated.
- The delay lines are plain shift registers with no stall input; the core never back-pressures.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release → all outputs 0 during reset; inReady=1 on the first edge after release; occupancy=0.
- Single job:
  - Push graph 128'h1, count 6'd2, tag 10'h3A at cycle 0; request at cycle 2.
  - Expect start=1, graphOut=1, extraDataOut=3A at cycle 6.
  - Expect startingConnectCountOut_DELAYED=2 at cycle 9 only; missedSlots=0.
- Back-to-back:
  - Push 16 jobs with tag i, graph = i<<i, then 16 consecutive requests.
  - Expect 16 consecutive start pulses in tag order 0..15; occupancy goes 16→0.
  - inReady=0 while occupancy=16.
- Empty FIFO:
  - 3 requests with nothing pushed → no start pulses; missedSlots=3.
  - A job pushed in the same cycle as a request is not popped by that request.
- Full boundary:
  - Fill to 16, then push and request in the same cycle → push refused (inReady=0); occupancy=15 afterwards.
  - The next push is accepted; ordering is intact.
- Mid-flight reset:
  - Issue 2 requests with a full FIFO, assert rst at cycle+2.
  - Expect no start pulses; occupancy=0; missedSlots=0 after release.
